// File: rtl/smg_pkg.sv
// smg_pkg: shared mode and segment constants for the seven-segment scan controller
package smg_pkg;
  localparam logic [1:0] SMG_MODE_STATIC = 2'b00;
  localparam logic [1:0] SMG_MODE_SCROLL = 2'b01;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  // active-low g..a with dp off; entry 0 is the rightmost element
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h84, 8'hA1, 8'hA7, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/smg_seg_decode.sv
// smg_seg_decode: nibble to active-low segment pattern with dash and blank overrides
module smg_seg_decode
  import smg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       hex_en,
  input  logic       blank,
  output logic [7:0] seg
);
  assign seg = blank ? SEG_BLANK : (!hex_en && nib > 4'd9) ? SEG_DASH : SEG_HEX[nib];
endmodule

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl: multiplexed seven-segment scanner with optional scrolling window
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W = 32,
  parameter int SCAN_DIV = 50000,
  parameter int SCROLL_DIV = 500
) (
  input  logic                  clk_smg,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  load,
  input  logic [1:0]            mode,
  input  logic                  hex_en,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] sel_smg,
  output logic [7:0]            data_in_smg,
  output logic                  scroll_wrap
);
  localparam int NUM_NIB = DATA_W / 4;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(SCROLL_DIV + 1);
  localparam int KW = $clog2(NUM_DIGITS);
  localparam int OW = $clog2(NUM_NIB);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_DIGITS - 1);
  localparam logic [OW-1:0] OFF_MAX = OW'(NUM_NIB - NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] SEL_TOP = {1'b1, {(NUM_DIGITS-1){1'b0}}};
  logic [PW-1:0] presc;
  logic [SW-1:0] scnt;
  logic [KW-1:0] k;
  logic [OW-1:0] offset;
  logic [DATA_W-1:0] disp_buf;
  logic [DATA_W-1:0] win_bits;
  logic [KW-1:0] hi;
  logic [3:0] nib;
  logic [7:0] seg;
  logic tick, scrolling, step;
  assign tick = presc == PRE_LAST;
  assign scrolling = mode == SMG_MODE_SCROLL;
  assign step = tick && scrolling && scnt == SCR_LAST;
  assign win_bits = disp_buf >> {offset, 2'b00};
  assign nib = win_bits[{k, 2'b00} +: 4];
  // highest nonzero window digit; digit 0 stays lit even for an all-zero window
  always_comb begin
    hi = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (win_bits[4*i +: 4] != 4'h0) hi = KW'(i);
  end
  smg_seg_decode u_dec (
    .nib    (nib),
    .hex_en (hex_en),
    .blank  (blank_lz && k > hi),
    .seg    (seg)
  );
  always_ff @(posedge clk_smg or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      scnt <= '0;
      k <= '0;
      offset <= '0;
      disp_buf <= '0;
      sel_smg <= '1;
      data_in_smg <= SEG_BLANK;
      scroll_wrap <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      scroll_wrap <= step && !load && offset == OFF_MAX;
      if (tick) begin
        k <= k == K_LAST ? '0 : k + KW'(1);
        sel_smg <= ~(SEL_TOP >> k);
        data_in_smg <= seg;
      end
      if (load) disp_buf <= in_data;
      if (load || !scrolling) begin
        offset <= '0;
        scnt <= '0;
      end else if (tick) begin
        scnt <= scnt == SCR_LAST ? '0 : scnt + SW'(1);
        if (scnt == SCR_LAST) offset <= offset == OFF_MAX ? '0 : offset + OW'(1);
      end
    end
  end
endmodule

// File: tb/tb_smg_scan_ctrl.sv
// tb_smg_scan_ctrl: directed and random stimulus against a cycle-level behavioural model
module tb_smg_scan_ctrl;
  localparam int ND = 4;
  localparam int DW = 32;
  localparam int SD = 4;
  localparam int SR = 2;
  logic clk_smg, rst, load, hex_en, blank_lz, scroll_wrap;
  logic [DW-1:0] in_data;
  logic [1:0] mode;
  logic [ND-1:0] sel_smg;
  logic [7:0] data_in_smg;
  int n_tests, n_fail;
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h84, 8'h8E};
  logic [DW-1:0] m_buf;
  int m_off, m_scnt, m_k, m_pcnt;
  logic [ND-1:0] e_sel;
  logic [7:0] e_seg;
  logic e_wrap;

  smg_scan_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD), .SCROLL_DIV(SR)) dut (
    .clk_smg     (clk_smg),
    .rst         (rst),
    .in_data     (in_data),
    .load        (load),
    .mode        (mode),
    .hex_en      (hex_en),
    .blank_lz    (blank_lz),
    .sel_smg     (sel_smg),
    .data_in_smg (data_in_smg),
    .scroll_wrap (scroll_wrap)
  );

  initial clk_smg = 1'b0;
  always #5 clk_smg = ~clk_smg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_buf = '0;
    m_off = 0;
    m_scnt = 0;
    m_k = 0;
    m_pcnt = 0;
    e_sel = '1;
    e_seg = 8'hFF;
    e_wrap = 1'b0;
  endtask

  task automatic model_step();
    int d [ND];
    int hi;
    bit tick;
    tick = (m_pcnt == SD - 1);
    m_pcnt = (m_pcnt + 1) % SD;
    e_wrap = 1'b0;
    if (tick) begin
      hi = 0;
      for (int i = 0; i < ND; i++) begin
        d[i] = int'((m_buf >> (4 * (m_off + i))) & 32'hF);
        if (d[i] != 0) hi = i;
      end
      e_sel = '1;
      e_sel[ND-1-m_k] = 1'b0;
      if (blank_lz && m_k > hi) e_seg = 8'hFF;
      else if (!hex_en && d[m_k] > 9) e_seg = 8'hBF;
      else e_seg = seg_tab[d[m_k]];
      m_k = (m_k + 1) % ND;
    end
    if (load) begin
      m_buf = in_data;
      m_off = 0;
      m_scnt = 0;
    end else if (mode != 2'b01) begin
      m_off = 0;
      m_scnt = 0;
    end else if (tick) begin
      m_scnt++;
      if (m_scnt == SR) begin
        m_scnt = 0;
        if (m_off == DW / 4 - ND) begin
          m_off = 0;
          e_wrap = 1'b1;
        end else m_off++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_smg);
    if (rst) model_step();
    else model_reset();
    #1;
    chk("sel", 32'(sel_smg), 32'(e_sel));
    chk("seg", 32'(data_in_smg), 32'(e_seg));
    chk("wrap", 32'(scroll_wrap), 32'(e_wrap));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [DW-1:0] v);
    load = 1'b1;
    in_data = v;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    int guard;
    int wraps;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    load = 1'b0;
    in_data = '0;
    mode = 2'b00;
    hex_en = 1'b1;
    blank_lz = 1'b0;
    model_reset();
    #12;
    chk("rst_sel", 32'(sel_smg), 32'hF);
    chk("rst_seg", 32'(data_in_smg), 32'hFF);
    chk("rst_wrap", 32'(scroll_wrap), 32'h0);
    rst = 1'b1;
    run(3);
    chk("pre_tick_sel", 32'(sel_smg), 32'hF);
    cycle();
    chk("first_tick_sel", 32'(sel_smg), 32'h7);
    chk("first_tick_seg", 32'(data_in_smg), 32'hC0);
    do_load(32'h0000_1234);
    run(40);
    hex_en = 1'b0;
    do_load(32'h0000_00AF);
    run(24);
    hex_en = 1'b1;
    blank_lz = 1'b1;
    do_load(32'h0000_0050);
    run(24);
    do_load(32'h0);
    run(24);
    blank_lz = 1'b0;
    mode = 2'b01;
    do_load(32'h8765_4321);
    wraps = 0;
    for (int i = 0; i < 5 * SR * SD; i++) begin
      cycle();
      wraps += int'(scroll_wrap);
    end
    chk("wraps_per_5_steps", 32'(wraps), 32'd1);
    guard = 0;
    while (!(m_pcnt == SD - 1 && m_scnt == SR - 1 && m_off == 4) && guard < 200) begin
      cycle();
      guard++;
    end
    if (guard >= 200) chk("coll_timeout", 32'(guard), 32'd0);
    do_load(32'h1111_1111);
    chk("coll_wrap", 32'(scroll_wrap), 32'h0);
    run(40);
    do_load(32'h8765_4321);
    guard = 0;
    while (m_off != 3 && guard < 200) begin
      cycle();
      guard++;
    end
    if (guard >= 200) chk("rst_off3_timeout", 32'(guard), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel_smg), 32'hF);
    chk("async_rst_seg", 32'(data_in_smg), 32'hFF);
    chk("async_rst_wrap", 32'(scroll_wrap), 32'h0);
    run(2);
    #3;
    rst = 1'b1;
    run(3);
    chk("rel_wait_sel", 32'(sel_smg), 32'hF);
    cycle();
    chk("rel_first_sel", 32'(sel_smg), 32'h7);
    chk("rel_first_seg", 32'(data_in_smg), 32'hC0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        load = 1'b1;
        in_data = $urandom >> (4 * $urandom_range(0, 7));
      end else load = 1'b0;
      if ($urandom_range(0, 60) == 0) mode = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      if ($urandom_range(0, 30) == 0) hex_en = 1'($urandom);
      if ($urandom_range(0, 30) == 0) blank_lz = 1'($urandom);
      cycle();
    end
    load = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
